vlg_ab_sequencer: RTL and testbench

VLG_AB_SEQUENCER -- requirements
Module: vlg_ab_sequencer

---
 rtl/vlg_ab_sequencer.sv | 161 ++++++++++++++++
 tb/tb_vlg_ab_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlg_ab_sequencer.sv
// ============================================================================
// vlg_ab_sequencer : table-driven a/b stimulus sequencer with z_in checking
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module vlg_ab_sequencer #(
  parameter int HOLD_CYC = 4,
  parameter int SKEW_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [2:0] cfg_data,
  input  logic [3:0] cfg_len,
  input  logic       start,
  input  logic       z_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] err_cnt,
  output logic       err_flag
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE_A = 3'd1,
    S_DRIVE_B = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam bit         C_HAS_SKEW  = (SKEW_CYC > 0);
  localparam logic [3:0] C_SKEW_LAST = C_HAS_SKEW ? 4'(SKEW_CYC - 1) : 4'd0;
  localparam logic [3:0] C_HOLD_LAST = 4'(HOLD_CYC - 1);

  state_t     r_state;
  logic [2:0] r_tbl [8];
  logic [3:0] r_len;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;

  logic [3:0] w_len_in;
  logic [2:0] w_entry;
  logic [2:0] w_nidx;
  logic [2:0] w_next;
  logic [2:0] w_first;
  logic       w_last;
  logic       w_mismatch;

  assign w_len_in   = (cfg_len > 4'd8) ? 4'd8 : cfg_len;
  assign w_entry    = r_tbl[r_idx];
  assign w_nidx     = r_idx + 3'd1;
  assign w_next     = r_tbl[w_nidx];
  assign w_first    = r_tbl[0];
  assign w_last     = ({1'b0, r_idx} == (r_len - 4'd1));
  assign w_mismatch = (z_in != w_entry[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_len    <= 4'd0;
      r_idx    <= 3'd0;
      r_cnt    <= 4'd0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= 4'd0;
      err_flag <= 1'b0;
      for (int i = 0; i < 8; i++) r_tbl[i] <= 3'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_we) r_tbl[cfg_addr] <= cfg_data;
          if (start) begin
            r_len    <= w_len_in;
            r_idx    <= 3'd0;
            r_cnt    <= 4'd0;
            err_cnt  <= 4'd0;
            err_flag <= 1'b0;
            if (w_len_in == 4'd0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              a       <= 1'b0;
              b       <= 1'b0;
            end else begin
              busy <= 1'b1;
              a    <= w_first[0];
              if (C_HAS_SKEW) begin
                r_state <= S_DRIVE_A;
              end else begin
                r_state <= S_DRIVE_B;
                b       <= w_first[1];
              end
            end
          end
        end

        S_DRIVE_A: begin
          if (r_cnt == C_SKEW_LAST) begin
            r_state <= S_DRIVE_B;
            r_cnt   <= 4'd0;
            a       <= w_entry[0];
            b       <= w_entry[1];
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_DRIVE_B: begin
          r_state <= S_HOLD;
          r_cnt   <= 4'd0;
        end

        S_HOLD: begin
          if (r_cnt == C_HOLD_LAST) begin
            // z_in is judged only once both inputs have settled for the full hold
            if (w_mismatch) begin
              err_flag <= 1'b1;
              if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
            end
            r_cnt <= 4'd0;
            if (w_last) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              a       <= 1'b0;
              b       <= 1'b0;
            end else begin
              r_idx <= w_nidx;
              a     <= w_next[0];
              if (C_HAS_SKEW) begin
                r_state <= S_DRIVE_A;
              end else begin
                r_state <= S_DRIVE_B;
                b       <= w_next[1];
              end
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vlg_ab_sequencer.sv
// ============================================================================
// tb_vlg_ab_sequencer : scoreboard bench driving a skewed and an unskewed DUT
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vlg_ab_sequencer;

  localparam int S0 = 1, H0 = 4;
  localparam int S1 = 0, H1 = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [2:0] cfg_data = 3'd0;
  logic [3:0] cfg_len = 4'd0;
  logic       start = 1'b0;
  int         z_mode = 0;

  logic       a0, b0, busy0, done0, ef0, z0;
  logic [3:0] ec0;
  logic       a1, b1, busy1, done1, ef1, z1;
  logic [3:0] ec1;

  // z_mode 0: z follows a&b, 1: stuck low, 2: stuck high
  assign z0 = (z_mode == 0) ? (a0 & b0) : (z_mode == 2);
  assign z1 = (z_mode == 0) ? (a1 & b1) : (z_mode == 2);

  always #5 clk = ~clk;

  vlg_ab_sequencer #(.HOLD_CYC(H0), .SKEW_CYC(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .z_in(z0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .err_cnt(ec0), .err_flag(ef0)
  );

  vlg_ab_sequencer #(.HOLD_CYC(H1), .SKEW_CYC(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .z_in(z1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .err_cnt(ec1), .err_flag(ef1)
  );

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       chk;
    logic [3:0] ec;
    logic       ef;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [2:0] tbl [8];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  task automatic put(input int sel, input exp_t e);
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected per-cycle outputs for one run, starting the cycle after start
  task automatic push_run(input int sel, input int s, input int h, input int n, input int zm);
    exp_t e;
    logic pb, ea, eb, ez, z;
    int   errs;
    pb = 1'b0;
    errs = 0;
    for (int k = 0; k < n; k++) begin
      ea = tbl[k][0];
      eb = tbl[k][1];
      ez = tbl[k][2];
      for (int i = 0; i < s; i++) begin
        e = '{a: ea, b: pb, busy: 1'b1, done: 1'b0, chk: 1'b0, ec: 4'd0, ef: 1'b0};
        put(sel, e);
      end
      for (int i = 0; i < 1 + h; i++) begin
        e = '{a: ea, b: eb, busy: 1'b1, done: 1'b0, chk: 1'b0, ec: 4'd0, ef: 1'b0};
        put(sel, e);
      end
      z = (zm == 0) ? (ea & eb) : (zm == 2);
      if (z != ez) errs++;
      pb = eb;
    end
    e = '{a: 1'b0, b: 1'b0, busy: 1'b0, done: 1'b1, chk: 1'b1,
          ec: 4'((errs > 15) ? 15 : errs), ef: (errs > 0)};
    put(sel, e);
    e.done = 1'b0;
    put(sel, e);
    put(sel, e);
  endtask

  task automatic mon(input int sel);
    exp_t       e;
    logic       ta, tb_, tbusy, tdone, tef;
    logic [3:0] tec;
    bit         have;
    ta    = (sel == 0) ? a0 : a1;
    tb_   = (sel == 0) ? b0 : b1;
    tbusy = (sel == 0) ? busy0 : busy1;
    tdone = (sel == 0) ? done0 : done1;
    tef   = (sel == 0) ? ef0 : ef1;
    tec   = (sel == 0) ? ec0 : ec1;
    have  = (sel == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      e = (sel == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("d%0d_a", sel), int'(ta), int'(e.a));
      chk($sformatf("d%0d_b", sel), int'(tb_), int'(e.b));
      chk($sformatf("d%0d_busy", sel), int'(tbusy), int'(e.busy));
      chk($sformatf("d%0d_done", sel), int'(tdone), int'(e.done));
      if (e.chk) begin
        chk($sformatf("d%0d_err_cnt", sel), int'(tec), int'(e.ec));
        chk($sformatf("d%0d_err_flag", sel), int'(tef), int'(e.ef));
      end
    end else begin
      chk($sformatf("d%0d_idle_busy", sel), int'(tbusy), 0);
      chk($sformatf("d%0d_idle_done", sel), int'(tdone), 0);
      chk($sformatf("d%0d_idle_ab", sel), int'({ta, tb_}), 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic write_entry(input logic [2:0] addr, input logic [2:0] data);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(posedge clk);
    tbl[addr] = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_run(input logic [3:0] len, input int zm, input bit poke);
    int n, pk, cyc;
    n = (len > 4'd8) ? 8 : int'(len);
    z_mode = zm;
    @(negedge clk);
    cfg_len = len;
    start = 1'b1;
    @(posedge clk);
    push_run(0, S0, H0, n, zm);
    push_run(1, S1, H1, n, zm);
    pk = (poke && n > 0) ? $urandom_range(n * (S1 + 1 + H1), 1) : 0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start    = (cyc == pk);
      cfg_we   = (cyc == pk);
      cfg_addr = 3'($urandom);
      cfg_data = 3'($urandom);
      cfg_len  = 4'($urandom);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    start = 1'b0;
    cfg_we = 1'b0;
    if (cyc > 300) begin
      n_chk++;
      $display("FAIL run_timeout: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_ab0"}, int'({a0, b0}), 0);
    chk({nm, "_ab1"}, int'({a1, b1}), 0);
    chk({nm, "_busy"}, int'({busy0, busy1}), 0);
    chk({nm, "_done"}, int'({done0, done1}), 0);
    chk({nm, "_err0"}, int'({ec0, ef0}), 0);
    chk({nm, "_err1"}, int'({ec1, ef1}), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = 3'd0;
    #1;
    check_quiet("reset");
    #20 rst_n = 1'b1;

    // Basic three-entry run, z follows a&b
    write_entry(3'd0, 3'b010);
    write_entry(3'd1, 3'b001);
    write_entry(3'd2, 3'b000);
    do_run(4'd3, 0, 1'b0);
    // Entry 0 now expects z=1: one mismatch
    write_entry(3'd0, 3'b110);
    do_run(4'd3, 0, 1'b1);
    // a and b both rising: skew visible only on the skewed instance
    write_entry(3'd0, 3'b011);
    do_run(4'd1, 0, 1'b0);
    // Empty run
    do_run(4'd0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int nw;
      nw = $urandom_range(4, 0);
      for (int w = 0; w < nw; w++) write_entry(3'($urandom), 3'($urandom));
      do_run(4'($urandom), $urandom_range(2, 0), 1'($urandom));
    end

    // Every entry mismatches, oversize length clamps to 8
    for (int i = 0; i < 8; i++) write_entry(3'(i), 3'b100);
    do_run(4'd15, 1, 1'b0);
    do_run(4'd12, 1, 1'b1);

    // Reset during HOLD of entry 1 of the skewed instance
    write_entry(3'd0, 3'b010);
    write_entry(3'd1, 3'b011);
    write_entry(3'd2, 3'b000);
    z_mode = 0;
    @(negedge clk);
    cfg_len = 4'd3;
    start = 1'b1;
    @(posedge clk);
    push_run(0, S0, H0, 3, 0);
    push_run(1, S1, H1, 3, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 8; i++) tbl[i] = 3'd0;
    #1;
    check_quiet("midrun_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    // Table was cleared by reset: all-zero entries, z stuck high mismatches each
    do_run(4'd2, 2, 1'b0);
    write_entry(3'd0, 3'b111);
    write_entry(3'd1, 3'b011);
    do_run(4'd2, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
